fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read sync_fifo into a valid/ready stream with packet framing.
// A 3-entry credit-managed buffer hides the FIFO read latency without an m_ready-to-rd_en path.
module fifo_stream_reader #(
    parameter int DW      = 16,
    parameter int PKT_LEN = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [15:0]   pkt_count
);

    localparam int          DEPTH     = 3;
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic [1:0]    cnt;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic          inflight;
    logic [15:0]   beat;
    logic [2:0]    credit_used;
    logic          capture;
    logic          pop;
    logic [DW-1:0] buffer [DEPTH];

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue only from registered state: a read is in flight or buffered counts against the 3 slots.
    // NOTE: both outputs are assigned on every pass through this block, so no latch is inferred.
    always_comb begin
        credit_used = {1'b0, cnt} + {2'b00, inflight};
        fifo_rd_en  = rstn & ~fifo_empty & (credit_used < 3'd3);
    end

    assign capture = inflight;
    assign pop     = m_valid & m_ready;
    assign m_valid = (cnt != 2'd0);
    assign m_data  = m_valid ? buffer[rd_ptr] : '0;
    assign m_last  = m_valid & (beat == LAST_BEAT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= 2'd0;
            inflight  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            beat      <= 16'd0;
            pkt_count <= 16'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) wr_ptr <= next_ptr(wr_ptr);
            if (pop)     rd_ptr <= next_ptr(rd_ptr);
            case ({capture, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
            if (pop) begin
                beat <= (beat == LAST_BEAT) ? 16'd0 : beat + 16'd1;
                if (m_last) pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // NOTE: the data storage has no reset; cnt gates its visibility, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (capture) begin
            assert (cnt != 2'd3);
            buffer[wr_ptr] <= fifo_dout;
        end
    end

endmodule
